mac_row_feeder: RTL and testbench
=================================

Name: mac_row_feeder

Overview:
- West-edge transmitter for one MAC row.
- Accepts a valid/ready word stream from the L0/IFIFO side.
- Emits the row's west inputs (data word plus 2-bit instruction) in two phases: kernel-load words, then execute vectors.
- After the last vector it holds idle instructions long enough to flush the row, then reports completion.

Parameters:
- bw, 4, data word width; equals the row's west input width.
- col, 8, number of tiles in the driven row; sets the kernel-load word count and the drain length.
- len_bw, 8, width of the execute-vector count.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle command pulse; sampled only in IDLE.
- num_vec  input  len_bw  execute-vector count; captured with start.
- in_data  input  bw  stream word.
- in_valid  input  1  stream word valid.
- in_ready  output  1  feeder accepts the word this cycle.
- out_w  output  bw  data to the row's west input; registered.
- inst_w  output  2  instruction to the row: bit1 = execute, bit0 = kernel load; registered.
- busy  output  1  a command is in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: asynchronous, active-low. While reset is low:
  - state = IDLE
  - out_w = 0, inst_w = 2'b00
  - busy = 0, done = 0
  - all counters = 0
  - Reset asserted mid-operation aborts the command immediately; no done pulse is issued.
- Handshake:
  - in_ready = 1 only in LOAD and EXEC; it is decoded from the state register.
  - A word transfers in a cycle with in_valid && in_ready.
  - A transferred word appears on out_w in the next cycle, with inst_w = 2'b01 (LOAD) or 2'b10 (EXEC).
  - In any cycle with no transfer, inst_w = 2'b00 and out_w holds its last value. Stall bubbles pass into the row as no-ops.
- States:
  - IDLE: when start = 1, capture num_vec into vec_len, clear counters, set busy = 1, go to LOAD.
  - LOAD: count transfers; on the col-th transfer go to GAP.
  - GAP: exactly one cycle with inst_w = 00 between the last load word and the first execute word. Then go to EXEC if vec_len != 0, else DRAIN.
  - EXEC: count transfers; on the vec_len-th transfer go to DRAIN.
  - DRAIN: col cycles of inst_w = 00. Then go to IDLE with done = 1 for one cycle and busy = 0 in that same cycle.
- Timing:
  - With start at cycle t, in_ready is first high at t+1.
  - With no stalls: the first load word is on out_w at t+2, and the first execute word is on out_w at t+col+3.
  - If the last EXEC transfer occurs at cycle e, then done = 1 at cycle e+col+1.
- Counters:
  - load counter: width $clog2(col)+1.
  - exec counter: len_bw bits.
  - vec_len max = 2^len_bw − 1; no wrap is possible.
- Corner cases:
  - start while busy: ignored; num_vec is not recaptured.
  - start and reset in the same cycle: reset wins.
  - in_valid with in_ready = 0: the word is not consumed; the source must hold it.
  - start is accepted in the same cycle done is high, since the state is IDLE then.
  - in_data is ignored outside LOAD and EXEC.

Optional Feature:
- Macro: MAC_ROW_FEEDER_PERF_EN.
- Defined:
  - Adds output stall_cnt [15:0].
  - Counts cycles in LOAD or EXEC with in_valid = 0.
  - Saturates at 16'hFFFF; cleared on an accepted start; reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Basic flow (col = 8): start with num_vec = 4, in_valid held high, words 1..12.
  - out_w = 1..8 with inst_w = 01 on consecutive cycles.
  - One cycle with inst_w = 00.
  - out_w = 9..12 with inst_w = 10.
  - 8 cycles with inst_w = 00, then done = 1 exactly at e+9.
- Stall: drop in_valid for 3 cycles after the 3rd load word.
  - 3 cycles of inst_w = 00 inserted; word order unchanged.
  - Load count still 8; stall_cnt = 3 when the macro is defined.
- Zero vectors: num_vec = 0.
  - 8 load words, then GAP, then 8 drain cycles, then done.
  - inst_w = 10 never appears.
- Command collision: start pulsed during EXEC with num_vec = 9.
  - Ignored; the original 4 vectors complete.
  - A new start on the done cycle is accepted: busy = 1 on the next cycle.
- Abort: reset low during the 5th load word.
  - out_w = 0, inst_w = 00, busy = 0, no done.
  - After release, a new command runs cleanly from IDLE.
- Maximum length: num_vec = 255.
  - Exactly 255 words with inst_w = 10; done appears once.

Source files
------------

// File: rtl/mac_row_feeder_if.sv
// Word stream from the L0/IFIFO side into the MAC row feeder (valid/ready).
interface mac_row_feeder_if #(
   parameter int bw = 4
);
   logic [bw-1:0] in_data;
   logic          in_valid;
   logic          in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/mac_row_feeder.sv
// West-edge feeder for one MAC row: kernel-load words, one gap cycle, execute
// vectors, then col idle cycles before done. Macro MAC_ROW_FEEDER_PERF_EN adds stall_cnt.
module mac_row_feeder #(
   parameter int bw     = 4,
   parameter int col    = 8,
   parameter int len_bw = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [len_bw-1:0] num_vec,
   mac_row_feeder_if.slave   s_in,
   output logic [bw-1:0]     out_w,
   output logic [1:0]        inst_w,
   output logic              busy,
   output logic              done
`ifdef MAC_ROW_FEEDER_PERF_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);
   localparam int CW = $clog2(col) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(col - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_GAP   = 3'd2,
      S_EXEC  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [CW-1:0]     r_lcnt;
   logic [len_bw-1:0] r_ecnt;
   logic [len_bw-1:0] r_vec_len;
   logic [bw-1:0]     r_out_w;
   logic [1:0]        r_inst_w;
   logic              r_busy;
   logic              r_done;
   logic              w_ready;
   logic              w_xfer;
   logic              w_accept;
   logic              w_last_exec;
   logic              w_finish;

   assign w_ready       = (r_state == S_LOAD) || (r_state == S_EXEC);
   assign w_xfer        = w_ready && s_in.in_valid;
   assign w_accept      = (r_state == S_IDLE) && start;
   assign w_last_exec   = (r_ecnt == (r_vec_len - len_bw'(1)));
   assign w_finish      = (r_state == S_DRAIN) && (w_next == S_IDLE);
   assign s_in.in_ready = w_ready;

   // next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) w_next = S_LOAD;
            else       w_next = S_IDLE;
         end
         S_LOAD: begin
            if (w_xfer && (r_lcnt == LAST_CNT)) w_next = S_GAP;
            else                                w_next = S_LOAD;
         end
         S_GAP: begin
            if (r_vec_len != '0) w_next = S_EXEC;
            else                 w_next = S_DRAIN;
         end
         S_EXEC: begin
            if (w_xfer && w_last_exec) w_next = S_DRAIN;
            else                       w_next = S_EXEC;
         end
         S_DRAIN: begin
            if (r_lcnt == LAST_CNT) w_next = S_IDLE;
            else                    w_next = S_DRAIN;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // counters, captured length and status flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_lcnt    <= '0;
         r_ecnt    <= '0;
         r_vec_len <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         // load counter is reused for the drain length; cleared on every state change
         if (r_state != w_next)
            r_lcnt <= '0;
         else if (((r_state == S_LOAD) && w_xfer) || (r_state == S_DRAIN))
            r_lcnt <= r_lcnt + CW'(1);
         else
            r_lcnt <= r_lcnt;

         if (w_accept)                        r_ecnt <= '0;
         else if ((r_state == S_EXEC) && w_xfer) r_ecnt <= r_ecnt + len_bw'(1);
         else                                 r_ecnt <= r_ecnt;

         if (w_accept) r_vec_len <= num_vec;
         else          r_vec_len <= r_vec_len;

         if (w_accept)      r_busy <= 1'b1;
         else if (w_finish) r_busy <= 1'b0;
         else               r_busy <= r_busy;

         r_done <= w_finish;
      end
   end

   // row outputs: bubbles become no-op instructions, data holds
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out_w  <= '0;
         r_inst_w <= 2'b00;
      end else if (w_xfer) begin
         r_out_w  <= s_in.in_data;
         r_inst_w <= (r_state == S_LOAD) ? 2'b01 : 2'b10;
      end else begin
         r_out_w  <= r_out_w;
         r_inst_w <= 2'b00;
      end
   end

   assign out_w  = r_out_w;
   assign inst_w = r_inst_w;
   assign busy   = r_busy;
   assign done   = r_done;

`ifdef MAC_ROW_FEEDER_PERF_EN
   logic [15:0] r_stall_cnt;

   // saturating count of starved cycles while the feeder is ready
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_stall_cnt <= 16'h0000;
      else if (w_accept)
         r_stall_cnt <= 16'h0000;
      else if (w_ready && !s_in.in_valid && (r_stall_cnt != 16'hFFFF))
         r_stall_cnt <= r_stall_cnt + 16'h0001;
      else
         r_stall_cnt <= r_stall_cnt;
   end

   assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_mac_row_feeder.sv
// Directed bench for mac_row_feeder: scoreboard of expected row words plus timing pins.
module tb_mac_row_feeder;
   localparam int BW  = 4;
   localparam int COL = 8;
   localparam int LB  = 8;

   typedef struct packed {
      logic [3:0] d;
      logic [1:0] i;
   } ent_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [LB-1:0] num_vec = '0;
   logic [BW-1:0] out_w;
   logic [1:0]    inst_w;
   logic          busy;
   logic          done;
`ifdef MAC_ROW_FEEDER_PERF_EN
   logic [15:0]   stall_cnt;
`endif

   mac_row_feeder_if #(.bw(BW)) bus ();

   mac_row_feeder #(.bw(BW), .col(COL), .len_bw(LB)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .num_vec (num_vec),
      .s_in    (bus.slave),
      .out_w   (out_w),
      .inst_w  (inst_w),
      .busy    (busy),
`ifdef MAC_ROW_FEEDER_PERF_EN
      .stall_cnt (stall_cnt),
`endif
      .done    (done)
   );

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   ent_t exp_q[$];
   ent_t e;
   int   m_nv = 0;
   int   exp_done_cyc = -1;
   int   first_load = -1;
   int   first_exec = -1;
   int   exec_cnt = 0;
   int   done_cyc = -1;
   int   dn_cnt = 0;
   int   t_start = 0;
   bit   chk_en = 1'b0;
   bit   m_active = 1'b0;
   bit   done_seen = 1'b0;
   logic ex_d;
   logic [3:0] m_last = 4'd0;

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [3:0] word(input int k);
      logic [31:0] v;
      v = k + 1;
      return v[3:0];
   endfunction

   // Row stream expected by the rules: col load words, then num_vec exec words;
   // done lands col cycles after the last exec word (col+1 after the last load word if no vectors).
   always @(negedge clk) begin
      if (chk_en) begin
         ex_d = m_active && (exp_q.size() == 0) && (cyc == exp_done_cyc);
         if (inst_w !== 2'b00) begin
            chk("word_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("out_w", out_w, e.d);
               chk("inst_w", inst_w, e.i);
               m_last = e.d;
               if (e.i == 2'b01 && first_load < 0) first_load = cyc;
               if (e.i == 2'b10) begin
                  exec_cnt++;
                  if (first_exec < 0) first_exec = cyc;
               end
               if (exp_q.size() == 0) exp_done_cyc = cyc + COL + ((m_nv == 0) ? 1 : 0);
            end
         end else begin
            chk("out_hold", out_w, m_last);
         end
         chk("done", done, ex_d);
         chk("busy", busy, m_active && !ex_d);
         if (done === 1'b1) dn_cnt++;
         if (ex_d) begin
            m_active  = 1'b0;
            done_seen = 1'b1;
            done_cyc  = cyc;
         end
      end
   end

   task automatic start_cmd(input int nv);
      exp_q.delete();
      for (int k = 0; k < COL + nv; k++) begin
         ent_t en;
         en.d = word(k);
         en.i = (k < COL) ? 2'b01 : 2'b10;
         exp_q.push_back(en);
      end
      m_nv = nv;
      exp_done_cyc = -1;
      first_load = -1;
      first_exec = -1;
      exec_cnt = 0;
      done_seen = 1'b0;
      t_start = cyc;
      start = 1'b1;
      num_vec = LB'(nv);
      bus.in_valid = 1'b1;
      bus.in_data = word(0);
      @(posedge clk); #1;
      start = 1'b0;
      m_active = 1'b1;
   endtask

   task automatic feed(input int nv, input int stall_at, input int stall_len,
                       input bit collide, input int abort_at, input bit chk_busy);
      int idx = 0;
      int rem = stall_len;
      int guard = 0;
      int tw = COL + nv;
      bit x;
      bit collided = 1'b0;
      bit first = 1'b1;
      while (idx < tw && guard < 3000) begin
         @(negedge clk); #1;
         if (first && chk_busy) chk("busy_after_done_start", busy, 1);
         first = 1'b0;
         x = bus.in_valid && bus.in_ready;
         @(posedge clk); #1;
         guard++;
         start = 1'b0;
         if (x) idx++;
         if (abort_at > 0 && idx == abort_at) begin
            chk_en = 1'b0;
            reset = 1'b0;
            #1;
            chk("abort_out_w", out_w, 0);
            chk("abort_inst_w", inst_w, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            chk("abort_in_ready", bus.in_ready, 0);
            bus.in_valid = 1'b0;
            return;
         end
         if (collide && !collided && idx == COL + 1) begin
            start = 1'b1;
            num_vec = LB'(9);
            collided = 1'b1;
         end
         if (rem > 0 && idx == stall_at) begin
            bus.in_valid = 1'b0;
            rem--;
         end else begin
            bus.in_valid = (idx < tw);
            bus.in_data = word(idx);
         end
      end
      chk("all_words_taken", idx, tw);
   endtask

   task automatic wait_done();
      int g = 0;
      while (!done_seen && g < 400) begin
         @(negedge clk); #1;
         g++;
      end
      chk("done_seen", done_seen, 1);
   endtask

   int dn_before;

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data = 4'd0;
      #12;
      chk("rst_out_w", out_w, 0);
      chk("rst_inst_w", inst_w, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      @(negedge clk);
      reset = 1'b1;
      m_last = 4'd0;
      chk_en = 1'b1;

      // basic flow
      @(posedge clk); #1;
      start_cmd(4);
      feed(4, 0, 0, 1'b0, 0, 1'b0);
      wait_done();
      chk("basic_first_load", first_load, t_start + 2);
      chk("basic_first_exec", first_exec, t_start + 11);
      chk("basic_done_cyc", done_cyc, t_start + 22);
      chk("basic_exec_cnt", exec_cnt, 4);
`ifdef MAC_ROW_FEEDER_PERF_EN
      chk("basic_stall_cnt", stall_cnt, 0);
`endif

      // three-cycle stall after the third load word
      repeat (3) @(posedge clk);
      #1;
      start_cmd(4);
      feed(4, 3, 3, 1'b0, 0, 1'b0);
      wait_done();
      chk("stall_first_exec", first_exec, t_start + 14);
      chk("stall_done_cyc", done_cyc, t_start + 25);
`ifdef MAC_ROW_FEEDER_PERF_EN
      chk("stall_stall_cnt", stall_cnt, 3);
`endif

      // zero vectors
      @(posedge clk); #1;
      start_cmd(0);
      feed(0, 0, 0, 1'b0, 0, 1'b0);
      wait_done();
      chk("zero_exec_cnt", exec_cnt, 0);
      chk("zero_done_cyc", done_cyc, t_start + 18);

      // start during EXEC ignored; start on the done cycle accepted
      @(posedge clk); #1;
      start_cmd(4);
      feed(4, 0, 0, 1'b1, 0, 1'b0);
      wait_done();
      chk("collide_exec_cnt", exec_cnt, 4);
      chk("collide_done_cyc", done_cyc, t_start + 22);
      start_cmd(2);
      feed(2, 0, 0, 1'b0, 0, 1'b1);
      wait_done();
      chk("chain_first_load", first_load, t_start + 2);
      chk("chain_exec_cnt", exec_cnt, 2);

      // abort with reset during the fifth load word
      @(posedge clk); #1;
      start_cmd(4);
      feed(4, 0, 0, 1'b0, 5, 1'b0);
      exp_q.delete();
      m_active = 1'b0;
      m_last = 4'd0;
      repeat (3) begin
         @(negedge clk);
         chk("abort_hold_done", done, 0);
         chk("abort_hold_busy", busy, 0);
      end
      #1;
      reset = 1'b1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      start_cmd(1);
      feed(1, 0, 0, 1'b0, 0, 1'b0);
      wait_done();
      chk("after_abort_done_cyc", done_cyc, t_start + 19);
      chk("after_abort_exec_cnt", exec_cnt, 1);

      // maximum vector count
      @(posedge clk); #1;
      dn_before = dn_cnt;
      start_cmd(255);
      feed(255, 0, 0, 1'b0, 0, 1'b0);
      wait_done();
      chk("max_exec_cnt", exec_cnt, 255);
      chk("max_done_cyc", done_cyc, t_start + 273);
      repeat (20) @(posedge clk);
      chk("max_done_once", dn_cnt - dn_before, 1);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
